// File: rtl/fb_bunch_sequencer.sv
// Bunch-train sequencer for the feedback DSP calc stage: times bunch strobes after a
// train trigger, gates the feedback/delay-loop enables and trips feedback on overflow.
//
// Handshake: there is no valid/ready pair here. trig is a single-cycle pulse that is
// only accepted in IDLE. bunch_strb is a single-cycle pulse that the calc stage must
// accept unconditionally. store_strb low is a level clear that wins over everything
// except rst.
module fb_bunch_sequencer #(
    parameter int MAX_BUNCHES = 4,
    parameter int CNT_W       = 8,
    parameter int MIN_SPACE   = 8,
    parameter int TAIL        = 8,
    parameter int OFLOW_TRIP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store_strb,
    input  logic             trig,
    input  logic [2:0]       num_bunches,
    input  logic [CNT_W-1:0] first_dly,
    input  logic [CNT_W-1:0] spacing,
    input  logic             fb_req,
    input  logic             delay_req,
    input  logic             dsp_oflow,
    output logic             bunch_strb,
    output logic [1:0]       bunch_idx,
    output logic             fb_en,
    output logic             delay_en,
    output logic             busy,
    output logic             fb_tripped,
    output logic [7:0]       oflow_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STRB  = 3'd2,
        ST_SPACE = 3'd3,
        ST_TAIL  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       strb_num, strb_num_next;
    logic [2:0]       eff_n;
    logic [CNT_W-1:0] eff_sp;
    logic [7:0]       train_oflow;
    logic             start;
    logic             oflow_hit;
    logic             trip_now;
    logic [2:0]       clamp_n;
    logic [CNT_W-1:0] clamp_sp;

    assign clamp_n  = (num_bunches > 3'(MAX_BUNCHES)) ? 3'(MAX_BUNCHES) : num_bunches;
    assign clamp_sp = (spacing < CNT_W'(MIN_SPACE)) ? CNT_W'(MIN_SPACE) : spacing;

    // busy is the registered view of the train, so overflow sampling follows it too.
    assign oflow_hit = busy & dsp_oflow;
    assign trip_now  = oflow_hit & (({1'b0, train_oflow} + 9'd1) >= 9'(OFLOW_TRIP));

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        strb_num_next = strb_num;
        start         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (trig && (num_bunches != 3'd0)) begin
                    state_next    = ST_WAIT;
                    cnt_next      = first_dly;
                    strb_num_next = 3'd0;
                    start         = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_next = ST_STRB;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            ST_STRB: begin
                strb_num_next = strb_num + 3'd1;
                if (strb_num == (eff_n - 3'd1)) begin
                    state_next = ST_TAIL;
                    cnt_next   = CNT_W'(TAIL - 1);
                end else begin
                    // SPACE lasts eff_sp-1 cycles so strobes land exactly eff_sp apart.
                    state_next = ST_SPACE;
                    cnt_next   = eff_sp - CNT_W'(2);
                end
            end
            ST_SPACE: begin
                if (cnt == '0) state_next = ST_STRB;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            ST_TAIL: begin
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!store_strb) begin
            state_next = ST_IDLE;
            start      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            strb_num    <= '0;
            eff_n       <= '0;
            eff_sp      <= '0;
            train_oflow <= '0;
            bunch_strb  <= 1'b0;
            bunch_idx   <= '0;
            fb_en       <= 1'b0;
            delay_en    <= 1'b0;
            busy        <= 1'b0;
            fb_tripped  <= 1'b0;
            oflow_cnt   <= '0;
        end else if (!store_strb) begin
            // Beam lost: abort the train but keep the last latched configuration.
            state       <= ST_IDLE;
            cnt         <= '0;
            strb_num    <= '0;
            train_oflow <= '0;
            bunch_strb  <= 1'b0;
            bunch_idx   <= '0;
            fb_en       <= 1'b0;
            delay_en    <= 1'b0;
            busy        <= 1'b0;
            fb_tripped  <= 1'b0;
            oflow_cnt   <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            strb_num <= strb_num_next;
            if (start) begin
                eff_n  <= clamp_n;
                eff_sp <= clamp_sp;
            end

            bunch_strb <= (state_next == ST_STRB);
            if (state_next == ST_STRB) bunch_idx <= strb_num[1:0];
            // Busy skips the trigger cycle itself and drops as TAIL expires.
            busy     <= (state != ST_IDLE) && (state_next != ST_IDLE);
            fb_en    <= busy & fb_req & ~fb_tripped;
            delay_en <= busy & delay_req;

            if (start)          train_oflow <= '0;
            else if (oflow_hit && (train_oflow != 8'hFF))
                                train_oflow <= train_oflow + 8'd1;
            if (oflow_hit && (oflow_cnt != 8'hFF)) oflow_cnt <= oflow_cnt + 8'd1;
            if (trip_now) fb_tripped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_bunch_sequencer.sv
// Bench for fb_bunch_sequencer: directed scenarios plus randomized trains, checked every
// cycle against an arithmetic train-schedule model.
module tb_fb_bunch_sequencer;

    localparam int TAIL_C = 8;
    localparam int MIN_SP = 8;
    localparam int MAX_B  = 4;
    localparam int TRIP   = 3;

    logic       clk;
    logic       rst;
    logic       store_strb;
    logic       trig;
    logic [2:0] num_bunches;
    logic [7:0] first_dly;
    logic [7:0] spacing;
    logic       fb_req;
    logic       delay_req;
    logic       dsp_oflow;
    logic       bunch_strb;
    logic [1:0] bunch_idx;
    logic       fb_en;
    logic       delay_en;
    logic       busy;
    logic       fb_tripped;
    logic [7:0] oflow_cnt;

    fb_bunch_sequencer dut (
        .clk(clk), .rst(rst), .store_strb(store_strb), .trig(trig),
        .num_bunches(num_bunches), .first_dly(first_dly), .spacing(spacing),
        .fb_req(fb_req), .delay_req(delay_req), .dsp_oflow(dsp_oflow),
        .bunch_strb(bunch_strb), .bunch_idx(bunch_idx), .fb_en(fb_en),
        .delay_en(delay_en), .busy(busy), .fb_tripped(fb_tripped), .oflow_cnt(oflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: one accepted train is described by its trigger edge and clamped parameters.
    bit         m_train = 0;
    int         m_t = 0, m_n = 0, m_sp = 0, m_fd = 0, m_last = 0;
    logic       m_busy = 0, m_strb = 0, m_fb_en = 0, m_delay_en = 0, m_trip = 0;
    logic [1:0] m_idx = 0;
    logic [7:0] m_ocnt = 0;
    int         m_toflow = 0;

    // Per-scenario observations of the DUT.
    int strb_cyc[$];
    int busy_cnt = 0;
    int fb_en_cnt = 0;
    int t_trig = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_edge();
        logic old_busy, old_trip;
        int   k;
        cyc++;
        if (rst || !store_strb) begin
            m_train = 0; m_busy = 0; m_strb = 0; m_fb_en = 0; m_delay_en = 0;
            m_trip = 0; m_idx = 0; m_ocnt = 0; m_toflow = 0;
        end else begin
            old_busy   = m_busy;
            old_trip   = m_trip;
            m_fb_en    = old_busy & fb_req & ~old_trip;
            m_delay_en = old_busy & delay_req;
            if (old_busy && dsp_oflow) begin
                if (m_ocnt != 8'hFF) m_ocnt = m_ocnt + 8'd1;
                m_toflow++;
                if (m_toflow >= TRIP) m_trip = 1'b1;
            end
            if (trig && num_bunches != 0 && (!m_train || cyc > m_last + TAIL_C + 1)) begin
                m_train  = 1;
                m_t      = cyc;
                m_n      = (int'(num_bunches) > MAX_B) ? MAX_B : int'(num_bunches);
                m_sp     = (int'(spacing) < MIN_SP) ? MIN_SP : int'(spacing);
                m_fd     = int'(first_dly);
                m_last   = m_t + 1 + m_fd + (m_n - 1) * m_sp;
                m_toflow = 0;
            end
            m_busy = m_train && cyc >= m_t + 1 && cyc <= m_last + TAIL_C;
            k = cyc - (m_t + 1 + m_fd);
            m_strb = m_train && k >= 0 && (k % m_sp) == 0 && (k / m_sp) < m_n;
            if (m_strb) m_idx = 2'(k / m_sp);
        end
    endtask

    task automatic compare();
        chk("bunch_strb", 32'(bunch_strb), 32'(m_strb));
        chk("bunch_idx",  32'(bunch_idx),  32'(m_idx));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("fb_en",      32'(fb_en),      32'(m_fb_en));
        chk("delay_en",   32'(delay_en),   32'(m_delay_en));
        chk("fb_tripped", 32'(fb_tripped), 32'(m_trip));
        chk("oflow_cnt",  32'(oflow_cnt),  32'(m_ocnt));
        if (bunch_strb === 1'b1) strb_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        if (fb_en === 1'b1) fb_en_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        strb_cyc.delete();
        busy_cnt  = 0;
        fb_en_cnt = 0;
    endtask

    function automatic int strb_off(input int k);
        if (strb_cyc.size() > k) return strb_cyc[k] - t_trig;
        return -1;
    endfunction

    // Pulse trig with the given config, then scramble config to show it is latched.
    task automatic fire(input int nb, input int fd, input int sp);
        num_bunches = 3'(nb);
        first_dly   = 8'(fd);
        spacing     = 8'(sp);
        trig        = 1'b1;
        t_trig      = cyc + 1;
        tick();
        trig        = 1'b0;
        num_bunches = 3'($urandom_range(0, 7));
        first_dly   = 8'($urandom);
        spacing     = 8'($urandom);
    endtask

    task automatic pulse_trig();
        num_bunches = 3'($urandom_range(1, 7));
        first_dly   = 8'($urandom_range(0, 3));
        spacing     = 8'($urandom_range(0, 12));
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    initial begin
        rst = 1'b1; store_strb = 1'b1; trig = 1'b0; num_bunches = '0;
        first_dly = '0; spacing = '0; fb_req = 1'b0; delay_req = 1'b0; dsp_oflow = 1'b0;
        run(3);
        rst = 1'b0;
        run(2);

        // Single bunch with a 5-cycle delay.
        fb_req = 1'b1; delay_req = 1'b1;
        clear_obs(); fire(1, 5, 10); run(25);
        chk("t1_strobe_count", 32'(strb_cyc.size()), 32'd1);
        chk("t1_strobe_time",  32'(strb_off(0)), 32'd6);
        chk("t1_busy_len",     32'(busy_cnt), 32'(6 + TAIL_C));

        // Three bunches at spacing 20, then spacing below the minimum.
        clear_obs(); fire(3, 0, 20); run(60);
        chk("t2_off0", 32'(strb_off(0)), 32'd1);
        chk("t2_off1", 32'(strb_off(1)), 32'd21);
        chk("t2_off2", 32'(strb_off(2)), 32'd41);
        chk("t2_last_idx", 32'(bunch_idx), 32'd2);
        clear_obs(); fire(3, 0, 3); run(40);
        chk("t2_min_off1", 32'(strb_off(1)), 32'd9);
        chk("t2_min_off2", 32'(strb_off(2)), 32'd17);

        // Clamp to MAX_BUNCHES, and num_bunches==0 ignored.
        clear_obs(); fire(7, 1, 8); run(50);
        chk("t3_clamp_count", 32'(strb_cyc.size()), 32'd4);
        clear_obs(); fire(0, 1, 8); run(15);
        chk("t3_zero_count", 32'(strb_cyc.size()), 32'd0);
        chk("t3_zero_busy",  32'(busy_cnt), 32'd0);

        // Overflow trip mid-train.
        clear_obs(); fire(4, 2, 12); run(8);
        dsp_oflow = 1'b1; run(3); dsp_oflow = 1'b0;
        chk("t4_tripped", 32'(fb_tripped), 32'd1);
        tick();
        chk("t4_fb_en_off", 32'(fb_en), 32'd0);
        run(60);
        chk("t4_strobes_continue", 32'(strb_cyc.size()), 32'd4);
        chk("t4_oflow_cnt", 32'(oflow_cnt), 32'd3);
        clear_obs(); fire(2, 0, 8); run(30);
        chk("t4_next_train_fb_en", 32'(fb_en_cnt), 32'd0);

        // Clear mid-SPACE.
        clear_obs(); fire(4, 0, 20); run(10);
        store_strb = 1'b0; tick(); store_strb = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tripped", 32'(fb_tripped), 32'd0);
        chk("t5_oflow_cnt", 32'(oflow_cnt), 32'd0);
        run(60);
        chk("t5_strobe_count", 32'(strb_cyc.size()), 32'd1);

        // trig together with clear: clear wins.
        clear_obs();
        store_strb = 1'b0; num_bunches = 3'd2; trig = 1'b1; tick();
        trig = 1'b0; store_strb = 1'b1; run(20);
        chk("t5_simul_count", 32'(strb_cyc.size()), 32'd0);

        // Retriggers during WAIT and TAIL are ignored.
        clear_obs(); fire(2, 4, 10); run(2);
        pulse_trig(); run(13);
        pulse_trig(); run(20);
        chk("t6_count", 32'(strb_cyc.size()), 32'd2);
        chk("t6_off0",  32'(strb_off(0)), 32'd5);
        chk("t6_off1",  32'(strb_off(1)), 32'd15);

        // Randomized trains against the model.
        for (int i = 0; i < 25; i++) begin
            fb_req    = 1'($urandom_range(0, 1));
            delay_req = 1'($urandom_range(0, 1));
            fire($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 24));
            for (int c = 0; c < int'($urandom_range(10, 150)); c++) begin
                dsp_oflow  = ($urandom_range(0, 15) == 0);
                store_strb = ($urandom_range(0, 250) != 0);
                if ($urandom_range(0, 40) == 0) begin
                    num_bunches = 3'($urandom_range(0, 7));
                    first_dly   = 8'($urandom_range(0, 10));
                    spacing     = 8'($urandom_range(0, 20));
                    trig = 1'b1;
                end else begin
                    trig = 1'b0;
                end
                tick();
            end
            trig = 1'b0; dsp_oflow = 1'b0; store_strb = 1'b1;
        end
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
